// File: rtl/bram_access_seq_fsm_if.sv
// rtl/bram_access_seq_fsm_if.sv - control/BRAM signal bundle for the BRAM access sequencer
// master drives the transfer request and beat enable; slave is the sequencer.
interface bram_access_seq_fsm_if #(
  parameter int CNT_BIT    = 31,
  parameter int ADDR_WIDTH = 12
);
  logic                  start_i;
  logic                  mode_i;
  logic [CNT_BIT-1:0]    cnt_val_i;
  logic [ADDR_WIDTH-1:0] base_addr_i;
  logic                  go_i;
  logic                  idle_o;
  logic                  run_o;
  logic                  drain_o;
  logic                  done_o;
  logic                  en_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [CNT_BIT-1:0]    cnt_o;
  logic                  rd_valid_o;

  modport master (
    output start_i, mode_i, cnt_val_i, base_addr_i, go_i,
    input  idle_o, run_o, drain_o, done_o, en_o, we_o, addr_o, cnt_o, rd_valid_o
  );

  modport slave (
    input  start_i, mode_i, cnt_val_i, base_addr_i, go_i,
    output idle_o, run_o, drain_o, done_o, en_o, we_o, addr_o, cnt_o, rd_valid_o
  );
endinterface

// File: rtl/bram_access_seq_fsm.sv
// rtl/bram_access_seq_fsm.sv - BRAM write/read beat sequencer with read-pipeline drain
// Issues one BRAM access per go_i cycle in RUN; read transfers wait RD_LATENCY cycles in DRAIN.
module bram_access_seq_fsm #(
  parameter int CNT_BIT    = 31,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  bram_access_seq_fsm_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [CNT_BIT-1:0]    cnt;
  logic [CNT_BIT-1:0]    len;
  logic [ADDR_WIDTH-1:0] base;
  logic                  mode;
  logic [2:0]            drain_cnt;
  logic [RD_LATENCY-1:0] rd_sr;
  logic                  beat;
  logic                  last_beat;
  logic                  drain_last;

  assign beat       = (state == RUN) && bus.go_i;
  assign last_beat  = beat && (cnt == len - CNT_BIT'(1));
  assign drain_last = (drain_cnt == 3'(RD_LATENCY - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        // zero-length transfers skip RUN entirely
        if (bus.start_i) state_nxt = (bus.cnt_val_i == '0) ? DONE : RUN;
      end
      RUN: begin
        if (last_beat) state_nxt = mode ? DRAIN : DONE;
      end
      DRAIN: begin
        if (drain_last) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      len       <= '0;
      base      <= '0;
      mode      <= 1'b0;
      drain_cnt <= '0;
      rd_sr     <= '0;
    end else begin
      if (state == IDLE && bus.start_i) begin
        len  <= bus.cnt_val_i;
        base <= bus.base_addr_i;
        mode <= bus.mode_i;
        cnt  <= '0;
      end else if (beat) begin
        cnt <= cnt + CNT_BIT'(1);
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;
      // read-valid tracks each read beat through the BRAM output pipeline
      rd_sr[0] <= beat & mode;
      for (int i = 1; i < RD_LATENCY; i++) rd_sr[i] <= rd_sr[i-1];
    end
  end

  assign bus.idle_o     = (state == IDLE);
  assign bus.run_o      = (state == RUN);
  assign bus.drain_o    = (state == DRAIN);
  assign bus.done_o     = (state == DONE);
  assign bus.en_o       = beat;
  assign bus.we_o       = beat & ~mode;
  assign bus.addr_o     = base + ADDR_WIDTH'(cnt);
  assign bus.cnt_o      = cnt;
  assign bus.rd_valid_o = rd_sr[RD_LATENCY-1];
endmodule

// File: tb/tb_bram_access_seq_fsm.sv
// tb/tb_bram_access_seq_fsm.sv - directed table-driven bench for bram_access_seq_fsm
// Built with RD_LATENCY=2, ADDR_WIDTH=12, CNT_BIT=31.
module tb_bram_access_seq_fsm;
  localparam int CB = 31;
  localparam int AW = 12;
  localparam int RL = 2;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bram_access_seq_fsm_if #(.CNT_BIT(CB), .ADDR_WIDTH(AW)) bus ();

  bram_access_seq_fsm #(.CNT_BIT(CB), .ADDR_WIDTH(AW), .RD_LATENCY(RL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          start;
    logic          mode;
    logic [CB-1:0] len;
    logic [AW-1:0] base;
    logic          go;
    logic [1:0]    st;
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [CB-1:0] cnt;
    logic          rv;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic start, input logic mode,
                              input int len, input int base, input logic go,
                              input int st, input logic en, input logic we,
                              input int addr, input int cnt, input logic rv);
    vec_t v;
    v.rst = rst; v.start = start; v.mode = mode; v.len = CB'(len); v.base = AW'(base);
    v.go = go; v.st = 2'(st); v.en = en; v.we = we; v.addr = AW'(addr);
    v.cnt = CB'(cnt); v.rv = rv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [49:0] act_v, exp_v;
  int   beats, rvs, drains, cyc;
  logic seen_done;

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.start_i = 1'b0; bus.mode_i = 1'b0; bus.cnt_val_i = '0;
    bus.base_addr_i = '0; bus.go_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_state", {60'd0, bus.idle_o, bus.run_o, bus.drain_o, bus.done_o}, 64'h8);
    chk("reset_en_we_rv", {61'd0, bus.en_o, bus.we_o, bus.rd_valid_o}, 64'h0);
    chk("reset_addr", 64'(bus.addr_o), 64'h0);
    chk("reset_cnt", 64'(bus.cnt_o), 64'h0);
    @(posedge clk);
    #1;

    // rst start mode len base go | st en we addr cnt rv
    // write len=4 base=0x010
    tbl.push_back(mk(0,1,0,4,'h010,1, 0,0,0,'h000,0,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h010,0,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h011,1,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h012,2,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h013,3,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 3,0,0,'h014,4,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 0,0,0,'h014,4,0));
    // read len=3 base=0x020
    tbl.push_back(mk(0,1,1,3,'h020,1, 0,0,0,'h014,4,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,0,'h020,0,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,0,'h021,1,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,0,'h022,2,1));
    tbl.push_back(mk(0,0,0,0,'h000,1, 2,0,0,'h023,3,1));
    tbl.push_back(mk(0,0,0,0,'h000,1, 2,0,0,'h023,3,1));
    tbl.push_back(mk(0,0,0,0,'h000,1, 3,0,0,'h023,3,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 0,0,0,'h023,3,0));
    // write len=3 base=0x100, go 1,0,0,1,1; start during DONE ignored
    tbl.push_back(mk(0,1,0,3,'h100,0, 0,0,0,'h023,3,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h100,0,0));
    tbl.push_back(mk(0,0,0,0,'h000,0, 1,0,0,'h101,1,0));
    tbl.push_back(mk(0,0,0,0,'h000,0, 1,0,0,'h101,1,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h101,1,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h102,2,0));
    tbl.push_back(mk(0,1,1,7,'h3AA,1, 3,0,0,'h103,3,0));
    tbl.push_back(mk(0,0,0,0,'h000,0, 0,0,0,'h103,3,0));
    // zero length
    tbl.push_back(mk(0,1,0,0,'h200,1, 0,0,0,'h103,3,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 3,0,0,'h200,0,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 0,0,0,'h200,0,0));
    // write len=5 base=0x300, start in RUN ignored
    tbl.push_back(mk(0,1,0,5,'h300,1, 0,0,0,'h200,0,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h300,0,0));
    tbl.push_back(mk(0,1,1,2,'h555,1, 1,1,1,'h301,1,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h302,2,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h303,3,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h304,4,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 3,0,0,'h305,5,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 0,0,0,'h305,5,0));
    // address wrap base=0xFFE len=4
    tbl.push_back(mk(0,1,0,4,'hFFE,1, 0,0,0,'h305,5,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'hFFE,0,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'hFFF,1,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h000,2,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h001,3,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 3,0,0,'h002,4,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 0,0,0,'h002,4,0));
    // reset during read RUN after 2 beats, then a fresh write
    tbl.push_back(mk(0,1,1,5,'h040,1, 0,0,0,'h002,4,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,0,'h040,0,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,0,'h041,1,0));
    tbl.push_back(mk(1,0,0,0,'h000,0, 1,0,0,'h042,2,1));
    tbl.push_back(mk(0,0,0,0,'h000,1, 0,0,0,'h000,0,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 0,0,0,'h000,0,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 0,0,0,'h000,0,0));
    tbl.push_back(mk(0,1,0,2,'h050,1, 0,0,0,'h000,0,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h050,0,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 1,1,1,'h051,1,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 3,0,0,'h052,2,0));
    tbl.push_back(mk(0,0,0,0,'h000,1, 0,0,0,'h052,2,0));

    for (int i = 0; i < tbl.size(); i++) begin
      reset           = tbl[i].rst;
      bus.start_i     = tbl[i].start;
      bus.mode_i      = tbl[i].mode;
      bus.cnt_val_i   = tbl[i].len;
      bus.base_addr_i = tbl[i].base;
      bus.go_i        = tbl[i].go;
      @(negedge clk);
      exp_v = {4'b1000 >> tbl[i].st, tbl[i].en, tbl[i].we, tbl[i].addr, tbl[i].cnt, tbl[i].rv};
      act_v = {bus.idle_o, bus.run_o, bus.drain_o, bus.done_o, bus.en_o, bus.we_o,
               bus.addr_o, bus.cnt_o, bus.rd_valid_o};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL row %0d: got %h expected %h", i, act_v, exp_v);
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;

    // read len=6 with irregular go_i: contiguous addresses, 6 read-valids, 2 drain cycles
    bus.start_i = 1'b1; bus.mode_i = 1'b1; bus.cnt_val_i = CB'(6);
    bus.base_addr_i = AW'('h7F0); bus.go_i = 1'b0;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    beats = 0; rvs = 0; drains = 0; seen_done = 1'b0;
    for (cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      bus.go_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if ((bus.idle_o + bus.run_o + bus.drain_o + bus.done_o) != 1)
        chk("onehot", {60'd0, bus.idle_o, bus.run_o, bus.drain_o, bus.done_o}, 64'h0);
      if (bus.en_o) begin
        chk("rd_addr", 64'(bus.addr_o), 64'('h7F0 + beats));
        chk("rd_we", 64'(bus.we_o), 64'h0);
        beats++;
      end
      if (bus.rd_valid_o) rvs++;
      if (bus.drain_o) drains++;
      if (bus.done_o) begin
        seen_done = 1'b1;
        chk("rd_final_cnt", 64'(bus.cnt_o), 64'd6);
      end
      @(posedge clk);
      #1;
    end
    chk("rd_done_seen", 64'(seen_done), 64'h1);
    chk("rd_beats", 64'(beats), 64'd6);
    chk("rd_valid_count", 64'(rvs), 64'd6);
    chk("rd_drain_cycles", 64'(drains), 64'(RL));
    @(negedge clk);
    chk("rd_back_idle", {60'd0, bus.idle_o, bus.run_o, bus.drain_o, bus.done_o}, 64'h8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
